mcp3008_spi_responder: RTL and testbench

- Synthesizable SPI responder that emulates an MCP3008 8-channel, 10-bit ADC. Mode 0,0 only: responder samples on SCK rising, drives on SCK falling.
- Serves as a loop-back target for the joystick SPI initiator in system sims and on-FPGA self-test.
- Channel values come from a parallel input bus, so benches and self-test logic can inject known codes.
- Decodes the 5-bit command, captures the selected value, and shifts null bit plus B9..B0 on MISO.

---
 rtl/mcp3008_pkg.sv | 40 ++++
 rtl/mcp3008_spi_responder_pin_sync.sv | 63 ++++++
 rtl/mcp3008_spi_responder.sv | 191 +++++++++++++++++++
 tb/tb_mcp3008_spi_responder.sv | 225 ++++++++++++++++++++++
 4 files changed

// File: rtl/mcp3008_pkg.sv
// rtl/mcp3008_pkg.sv - shared constants, FSM states and channel-value helper for the MCP3008 responder
package mcp3008_pkg;

    localparam int DATA_W   = 10;
    localparam int N_CH     = 8;
    localparam int CMD_BITS = 4;

    typedef enum logic [2:0] {
        IDLE,
        WAIT_START,
        CMD,
        SAMPLE,
        DATA,
        TAIL
    } state_e;

    // Single-ended returns CH(chan). Differential pairs CH(2p)/CH(2p+1) with
    // p = chan[2:1]; chan[0] picks which one is IN+, which is the same as
    // IN+ = CH(chan), IN- = CH(chan ^ 1). Negative differences read as 0.
    function automatic logic [DATA_W-1:0] chan_value(
        input logic [N_CH*DATA_W-1:0] ch,
        input logic                   sgl,
        input logic [2:0]             chan
    );
        logic [DATA_W-1:0] in_p;
        logic [DATA_W-1:0] in_n;
        logic [DATA_W:0]   diff;
        in_p = ch[int'(chan) * DATA_W +: DATA_W];
        in_n = ch[int'(chan ^ 3'b001) * DATA_W +: DATA_W];
        diff = {1'b0, in_p} - {1'b0, in_n};
        if (sgl) begin
            return in_p;
        end
        if (diff[DATA_W]) begin
            return '0;
        end
        return diff[DATA_W-1:0];
    endfunction

endpackage

// File: rtl/mcp3008_spi_responder_pin_sync.sv
// rtl/mcp3008_spi_responder_pin_sync.sv - SPI pin synchronizer with SCK edge detect
//
// Module spi_pin_sync
//   clk, rst_n          system clock, asynchronous active-low reset
//   spi_sck/cs/mosi     raw pins from the initiator
//   sck_rise, sck_fall  one-clk pulses on synchronized SCK edges
//   cs_level, mosi_level synchronized levels
// SYNC_STAGES = 0 bypasses the synchronizer (initiator on the same clk).
module spi_pin_sync #(
    parameter int SYNC_STAGES = 2
) (
    input  logic clk,
    input  logic rst_n,
    input  logic spi_sck,
    input  logic spi_cs,
    input  logic spi_mosi,
    output logic sck_rise,
    output logic sck_fall,
    output logic cs_level,
    output logic mosi_level
);

    // Bit order {cs, sck, mosi}. CS resets to 0 (looks active) so that a
    // transfer already in progress at reset release produces no falling edge
    // and is ignored until CS is cycled.
    logic [2:0] pins_s;
    logic       sck_q;

    generate
        if (SYNC_STAGES == 0) begin : g_bypass
            assign pins_s = {spi_cs, spi_sck, spi_mosi};
        end else begin : g_sync
            logic [2:0] stage_q [SYNC_STAGES];
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    for (int i = 0; i < SYNC_STAGES; i++) begin
                        stage_q[i] <= 3'b000;
                    end
                end else begin
                    stage_q[0] <= {spi_cs, spi_sck, spi_mosi};
                    for (int i = 1; i < SYNC_STAGES; i++) begin
                        stage_q[i] <= stage_q[i-1];
                    end
                end
            end
            assign pins_s = stage_q[SYNC_STAGES-1];
        end
    endgenerate

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sck_q <= 1'b0;
        end else begin
            sck_q <= pins_s[1];
        end
    end

    assign sck_rise   = pins_s[1] & ~sck_q;
    assign sck_fall   = ~pins_s[1] & sck_q;
    assign cs_level   = pins_s[2];
    assign mosi_level = pins_s[0];

endmodule

// File: rtl/mcp3008_spi_responder.sv
// rtl/mcp3008_spi_responder.sv - MCP3008 ADC emulator, SPI mode 0,0 responder
//
// Ports: clk, rst_n (async active-low); spi_sck/spi_cs/spi_mosi in,
// spi_miso/miso_oe out; ch_data = N_CH packed DATA_W-bit channel codes
// (CHn at [n*DATA_W +: DATA_W]); cmd_valid/cmd_single/cmd_chan report the
// decoded command; xfer_done/xfer_abort pulse on CS deassert.
// Optional macro MCP3008_LSB_TRAIL_EN: after B0, repeat B1..B9 LSB-first.
module mcp3008_spi_responder
    import mcp3008_pkg::*;
#(
    parameter int DATA_W      = mcp3008_pkg::DATA_W,
    parameter int N_CH        = mcp3008_pkg::N_CH,
    parameter int SYNC_STAGES = 2
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   spi_sck,
    input  logic                   spi_cs,
    input  logic                   spi_mosi,
    output logic                   spi_miso,
    output logic                   miso_oe,
    input  logic [N_CH*DATA_W-1:0] ch_data,
    output logic                   cmd_valid,
    output logic                   cmd_single,
    output logic [2:0]             cmd_chan,
    output logic                   xfer_done,
    output logic                   xfer_abort
);

    localparam int CW = $clog2(DATA_W + 1);

    logic sck_rise, sck_fall, cs_level, mosi_level;
    logic cs_q, cs_rise, cs_fall;

    state_e            state_q, state_d;
    logic [CW-1:0]     cnt_q, cnt_d;
    logic [2:0]        cmd_sr_q, cmd_sr_d;
    logic [DATA_W-1:0] value_q, value_d;
    logic              b0_sent_q, b0_sent_d;
    logic [3:0]        full_cmd;

    logic miso_d, oe_d, valid_d, single_d, done_d, abort_d;
    logic [2:0] chan_d;

    spi_pin_sync #(.SYNC_STAGES(SYNC_STAGES)) u_pin_sync (
        .clk        (clk),
        .rst_n      (rst_n),
        .spi_sck    (spi_sck),
        .spi_cs     (spi_cs),
        .spi_mosi   (spi_mosi),
        .sck_rise   (sck_rise),
        .sck_fall   (sck_fall),
        .cs_level   (cs_level),
        .mosi_level (mosi_level)
    );

    assign cs_rise  = cs_level & ~cs_q;
    assign cs_fall  = ~cs_level & cs_q;
    assign full_cmd = {cmd_sr_q, mosi_level};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cs_q       <= 1'b0;
            state_q    <= IDLE;
            cnt_q      <= '0;
            cmd_sr_q   <= '0;
            value_q    <= '0;
            b0_sent_q  <= 1'b0;
            spi_miso   <= 1'b0;
            miso_oe    <= 1'b0;
            cmd_valid  <= 1'b0;
            cmd_single <= 1'b0;
            cmd_chan   <= '0;
            xfer_done  <= 1'b0;
            xfer_abort <= 1'b0;
        end else begin
            cs_q       <= cs_level;
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            cmd_sr_q   <= cmd_sr_d;
            value_q    <= value_d;
            b0_sent_q  <= b0_sent_d;
            spi_miso   <= miso_d;
            miso_oe    <= oe_d;
            cmd_valid  <= valid_d;
            cmd_single <= single_d;
            cmd_chan   <= chan_d;
            xfer_done  <= done_d;
            xfer_abort <= abort_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        cmd_sr_d  = cmd_sr_q;
        value_d   = value_q;
        b0_sent_d = b0_sent_q;
        miso_d    = spi_miso;
        oe_d      = miso_oe;
        valid_d   = 1'b0;
        single_d  = cmd_single;
        chan_d    = cmd_chan;
        done_d    = 1'b0;
        abort_d   = 1'b0;

        // CS deassert takes priority over any SCK edge seen in the same clk.
        if (cs_rise) begin
            if (state_q != IDLE) begin
                state_d = IDLE;
                oe_d    = 1'b0;
                miso_d  = 1'b0;
                done_d  = b0_sent_q;
                abort_d = !b0_sent_q && (state_q != WAIT_START);
            end
        end else begin
            case (state_q)
                IDLE: begin
                    oe_d   = 1'b0;
                    miso_d = 1'b0;
                    if (cs_fall) begin
                        state_d   = WAIT_START;
                        b0_sent_d = 1'b0;
                    end
                end
                WAIT_START: begin
                    if (sck_rise && mosi_level) begin
                        state_d = CMD;
                        cnt_d   = '0;
                    end
                end
                CMD: begin
                    if (sck_rise) begin
                        cmd_sr_d = full_cmd[2:0];
                        cnt_d    = cnt_q + 1'b1;
                        if (cnt_q == CW'(CMD_BITS - 1)) begin
                            valid_d  = 1'b1;
                            single_d = full_cmd[3];
                            chan_d   = full_cmd[2:0];
                            value_d  = chan_value(ch_data, full_cmd[3], full_cmd[2:0]);
                            state_d  = SAMPLE;
                            cnt_d    = '0;
                        end
                    end
                end
                SAMPLE: begin
                    // The fall right after the capture edge stays high-Z; the
                    // null bit goes out on the fall following the next rise.
                    if (sck_rise) begin
                        cnt_d = CW'(1);
                    end else if (sck_fall && cnt_q == CW'(1)) begin
                        oe_d    = 1'b1;
                        miso_d  = 1'b0;
                        cnt_d   = CW'(DATA_W - 1);
                        state_d = DATA;
                    end
                end
                DATA: begin
                    if (sck_fall) begin
                        miso_d = value_q[cnt_q];
                        if (cnt_q == '0) begin
                            b0_sent_d = 1'b1;
                            state_d   = TAIL;
                            cnt_d     = CW'(1);
                        end else begin
                            cnt_d = cnt_q - 1'b1;
                        end
                    end
                end
                TAIL: begin
                    if (sck_fall) begin
`ifdef MCP3008_LSB_TRAIL_EN
                        if (cnt_q < CW'(DATA_W)) begin
                            miso_d = value_q[cnt_q];
                            cnt_d  = cnt_q + 1'b1;
                        end else begin
                            miso_d = 1'b0;
                        end
`else
                        miso_d = 1'b0;
`endif
                    end
                end
                default: begin
                    state_d = IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mcp3008_spi_responder.sv
// tb/tb_mcp3008_spi_responder.sv - self-checking bench for mcp3008_spi_responder
module tb_mcp3008_spi_responder;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        spi_sck;
    logic        spi_cs;
    logic        spi_mosi;
    logic        spi_miso;
    logic        miso_oe;
    logic [79:0] ch_data;
    logic        cmd_valid;
    logic        cmd_single;
    logic [2:0]  cmd_chan;
    logic        xfer_done;
    logic        xfer_abort;

    int checks   = 0;
    int failures = 0;
    int n_valid  = 0;
    int n_done   = 0;
    int n_abort  = 0;

    always #5 clk = ~clk;

    mcp3008_spi_responder #(.DATA_W(10), .N_CH(8), .SYNC_STAGES(2)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .spi_sck    (spi_sck),
        .spi_cs     (spi_cs),
        .spi_mosi   (spi_mosi),
        .spi_miso   (spi_miso),
        .miso_oe    (miso_oe),
        .ch_data    (ch_data),
        .cmd_valid  (cmd_valid),
        .cmd_single (cmd_single),
        .cmd_chan   (cmd_chan),
        .xfer_done  (xfer_done),
        .xfer_abort (xfer_abort)
    );

    always @(negedge clk) begin
        if (cmd_valid)  n_valid++;
        if (xfer_done)  n_done++;
        if (xfer_abort) n_abort++;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: time limit reached");
        $fatal(1, "watchdog");
    end

    typedef struct {
        string       name;
        logic        sgl;
        logic [2:0]  chan;
        int          lead;
        logic [79:0] ch;
        logic [9:0]  exp;
    } vec_t;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // CHn = 0x040 + n*0x11 unless overridden.
    function automatic logic [79:0] base_ch();
        logic [79:0] v;
        for (int n = 0; n < 8; n++) begin
            v[n*10 +: 10] = 10'(10'h040 + n * 10'h011);
        end
        return v;
    endfunction

    function automatic logic [79:0] set_ch(input logic [79:0] v, input int n, input logic [9:0] x);
        logic [79:0] r;
        r = v;
        r[n*10 +: 10] = x;
        return r;
    endfunction

    task automatic cs_low();
        spi_cs = 1'b0;
        repeat (4) @(negedge clk);
    endtask

    task automatic cs_high();
        spi_cs = 1'b1;
        repeat (6) @(negedge clk);
    endtask

    // n rises at SCK = clk/8; MISO and OE are sampled just before each rise.
    task automatic spi_run(input logic [4:0] cmd, input int lead, input int n, input int chg_r,
                           input logic [79:0] alt, output logic [63:0] mb, output logic [63:0] ob);
        mb = '0;
        ob = '0;
        for (int r = 0; r < n; r++) begin
            if (r >= lead && r < lead + 5) spi_mosi = cmd[4 - (r - lead)];
            else spi_mosi = 1'b0;
            repeat (4) @(negedge clk);
            mb[r] = spi_miso;
            ob[r] = miso_oe;
            spi_sck = 1'b1;
            repeat (4) @(negedge clk);
            if (r == chg_r) ch_data = alt;
            spi_sck = 1'b0;
        end
    endtask

    task automatic do_full(input string name, input logic sgl, input logic [2:0] chan, input int lead,
                           input logic [79:0] ch, input logic [9:0] exp);
        logic [63:0] mb, ob;
        logic [9:0]  got;
        int v0, d0, a0;
        ch_data = ch;
        v0 = n_valid; d0 = n_done; a0 = n_abort;
        cs_low();
        // ch_data is scrambled after r=lead+6; the captured value must hold.
        spi_run({1'b1, sgl, chan}, lead, lead + 17, lead + 6, ~ch, mb, ob);
        check({name, " oe_r5"}, 32'(ob[lead + 5]), 0);
        check({name, " oe_r6"}, 32'(ob[lead + 6]), 1);
        check({name, " null"}, 32'(mb[lead + 6]), 0);
        for (int k = 0; k < 10; k++) got[9 - k] = mb[lead + 7 + k];
        check({name, " data"}, 32'(got), 32'(exp));
        check({name, " single"}, 32'(cmd_single), 32'(sgl));
        check({name, " chan"}, 32'(cmd_chan), 32'(chan));
        check({name, " valid_cnt"}, 32'(n_valid - v0), 1);
        cs_high();
        check({name, " done_cnt"}, 32'(n_done - d0), 1);
        check({name, " abort_cnt"}, 32'(n_abort - a0), 0);
        check({name, " oe_after"}, 32'({miso_oe, spi_miso}), 0);
    endtask

    vec_t vecs[7];

    initial begin
        logic [63:0] mb, ob;
        logic [8:0]  tr;
        logic [9:0]  got;
        int v0, d0, a0;

        vecs[0] = '{"se_ch0",    1'b1, 3'd0, 0, set_ch(base_ch(), 0, 10'h2A5), 10'h2A5};
        vecs[1] = '{"diff_001",  1'b0, 3'd1, 0, set_ch(set_ch(base_ch(), 0, 10'd100), 1, 10'd350), 10'd250};
        vecs[2] = '{"diff_clamp",1'b0, 3'd1, 0, set_ch(set_ch(base_ch(), 0, 10'd400), 1, 10'd350), 10'd0};
        vecs[3] = '{"lead3_ch7", 1'b1, 3'd7, 3, set_ch(base_ch(), 7, 10'h3FF), 10'h3FF};
        vecs[4] = '{"diff_110",  1'b0, 3'd6, 0, set_ch(set_ch(base_ch(), 6, 10'h3FF), 7, 10'h001), 10'h3FE};
        vecs[5] = '{"diff_011",  1'b0, 3'd3, 1, base_ch(), 10'h011};
        vecs[6] = '{"se_ch5_0",  1'b1, 3'd5, 0, set_ch(~base_ch(), 5, 10'h000), 10'h000};

        rst_n = 1'b0; spi_cs = 1'b1; spi_sck = 1'b0; spi_mosi = 1'b0; ch_data = '0;
        #1;
        check("reset_outputs", 32'({spi_miso, miso_oe, cmd_valid, cmd_single, cmd_chan, xfer_done, xfer_abort}), 0);
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        repeat (6) @(negedge clk);
        check("idle_outputs", 32'({spi_miso, miso_oe, cmd_valid, xfer_done, xfer_abort}), 0);
        check("idle_no_pulse", 32'(n_valid + n_done + n_abort), 0);

        for (int i = 0; i < 7; i++) begin
            do_full(vecs[i].name, vecs[i].sgl, vecs[i].chan, vecs[i].lead, vecs[i].ch, vecs[i].exp);
        end

        // CS rises after r=9: abort, then a clean transfer on CH3.
        ch_data = set_ch(base_ch(), 3, 10'h155);
        d0 = n_done; a0 = n_abort;
        cs_low();
        spi_run(5'b11011, 0, 10, -1, '0, mb, ob);
        check("abort oe_before", 32'(miso_oe), 1);
        cs_high();
        check("abort abort_cnt", 32'(n_abort - a0), 1);
        check("abort done_cnt", 32'(n_done - d0), 0);
        check("abort oe_after", 32'(miso_oe), 0);
        do_full("after_abort_ch3", 1'b1, 3'd3, 0, set_ch(base_ch(), 3, 10'h155), 10'h155);

        // Reset asserted at r=8, SCK keeps toggling with CS still low.
        ch_data = set_ch(base_ch(), 2, 10'h3C3);
        v0 = n_valid; d0 = n_done; a0 = n_abort;
        cs_low();
        spi_run(5'b11010, 0, 9, -1, '0, mb, ob);
        rst_n = 1'b0;
        #1;
        check("rst_mid outputs", 32'({spi_miso, miso_oe, cmd_valid, cmd_single, cmd_chan, xfer_done, xfer_abort}), 0);
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        spi_mosi = 1'b1;
        for (int i = 0; i < 8; i++) begin
            repeat (4) @(negedge clk);
            spi_sck = 1'b1;
            repeat (4) @(negedge clk);
            spi_sck = 1'b0;
        end
        check("rst_mid ignored_valid", 32'(n_valid - v0), 1);
        check("rst_mid oe", 32'(miso_oe), 0);
        cs_high();
        check("rst_mid done_cnt", 32'(n_done - d0), 0);
        check("rst_mid abort_cnt", 32'(n_abort - a0), 0);
        do_full("after_reset_ch2", 1'b1, 3'd2, 0, set_ch(base_ch(), 2, 10'h3C3), 10'h3C3);

        // 26 rises on 0x201: tail bits r=17..25.
        ch_data = set_ch(base_ch(), 0, 10'h201);
        d0 = n_done;
        cs_low();
        spi_run(5'b11000, 0, 26, -1, '0, mb, ob);
        for (int k = 0; k < 10; k++) got[9 - k] = mb[7 + k];
        check("trail data", 32'(got), 32'h201);
        for (int j = 0; j < 9; j++) tr[j] = mb[17 + j];
`ifdef MCP3008_LSB_TRAIL_EN
        check("trail bits", 32'(tr), 32'h100);
`else
        check("trail bits", 32'(tr), 32'h000);
`endif
        check("trail oe_r25", 32'(ob[25]), 1);
        cs_high();
        check("trail done_cnt", 32'(n_done - d0), 1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
